// File: rtl/skid_pipeline_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : skid_pipeline_register_pkg
//  Brief    : Shared definitions for the two-entry skid pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
package skid_pipeline_register_pkg;

   // Occupancy state of the two-entry buffer (MAIN drives the outputs).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   // Number of held entries for a given state.
   function automatic logic [1:0] occupancy_of(input skid_state_t s);
      logic [1:0] n;
      n = 2'd0;
      case (s)
         ST_EMPTY: n = 2'd0;
         ST_ONE:   n = 2'd1;
         ST_FULL:  n = 2'd2;
         default:  n = 2'd0;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/skid_pipeline_register.sv
`default_nettype none
// ============================================================================
//  Module   : skid_pipeline_register
//  Brief    : Two-entry valid/ready pipeline register with a registered
//             IN_READY, synchronous flush and a saturating stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module skid_pipeline_register
   import skid_pipeline_register_pkg::*;
#(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 101,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FLUSH,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [CTRL_W-1:0] IN_CTRL,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [CTRL_W-1:0] OUT_CTRL,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic [1:0]        OCCUPANCY,
   output logic [CNT_W-1:0]  STALL_CNT
);

   skid_state_t       r_state;
   logic              r_in_ready;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic [DATA_W-1:0] r_skid_data;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_out_valid;
   logic w_in_fire;
   logic w_out_fire;
   logic w_main_load_in;
   logic w_main_load_skid;
   logic w_skid_load_in;
   logic w_stall;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_fire   = IN_VALID & r_in_ready;
   assign w_out_fire  = w_out_valid & OUT_READY;
   assign w_stall     = w_out_valid & ~OUT_READY;

   // Load strobes shared by the ctrl (reset) and data (unreset) registers.
   // A flush suppresses every load, so a same-cycle input is discarded.
   assign w_main_load_in   = ~FLUSH & w_in_fire &
                             ((r_state == ST_EMPTY) | ((r_state == ST_ONE) & w_out_fire));
   assign w_skid_load_in   = ~FLUSH & w_in_fire & (r_state == ST_ONE) & ~w_out_fire;
   assign w_main_load_skid = ~FLUSH & (r_state == ST_FULL) & w_out_fire;

   // Occupancy FSM with registered IN_READY and the reset/flush-cleared ctrl fields.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b0;
         r_main_ctrl <= '0;
         r_skid_ctrl <= '0;
      end else if (FLUSH) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_main_ctrl <= '0;
         r_skid_ctrl <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               r_in_ready <= 1'b1;
               if (w_in_fire) r_state <= ST_ONE;
            end
            ST_ONE: begin
               if (w_in_fire && !w_out_fire) begin
                  r_state    <= ST_FULL;
                  r_in_ready <= 1'b0;
               end else begin
                  r_in_ready <= 1'b1;
                  if (!w_in_fire && w_out_fire) r_state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  r_state    <= ST_ONE;
                  r_in_ready <= 1'b1;
               end else begin
                  r_in_ready <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_EMPTY;
               r_in_ready <= 1'b1;
            end
         endcase

         if (w_main_load_in)        r_main_ctrl <= IN_CTRL;
         else if (w_main_load_skid) r_main_ctrl <= r_skid_ctrl;
         if (w_skid_load_in)        r_skid_ctrl <= IN_CTRL;
      end
   end

   // Data payload: no reset, written only on an actual load so idle cycles do not toggle it.
   always_ff @(posedge CLK) begin
      if (w_main_load_in)        r_main_data <= IN_DATA;
      else if (w_main_load_skid) r_main_data <= r_skid_data;
      if (w_skid_load_in)        r_skid_data <= IN_DATA;
   end

   // Saturating count of cycles where an entry is offered but not taken; flush leaves it alone.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign IN_READY  = r_in_ready;
   assign OUT_VALID = w_out_valid;
   assign OUT_CTRL  = w_out_valid ? r_main_ctrl : '0;
   assign OUT_DATA  = r_main_data;
   assign OCCUPANCY = occupancy_of(r_state);
   assign STALL_CNT = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_skid_pipeline_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_skid_pipeline_register
//  Brief    : Self-checking bench for skid_pipeline_register against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_skid_pipeline_register;

   localparam int CW = 8;
   localparam int DW = 101;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          FLUSH;
   logic          IN_VALID;
   logic          OUT_READY;
   logic [CW-1:0] IN_CTRL;
   logic [DW-1:0] IN_DATA;

   logic          IN_READY,  IN_READY4;
   logic          OUT_VALID, OUT_VALID4;
   logic [CW-1:0] OUT_CTRL,  OUT_CTRL4;
   logic [DW-1:0] OUT_DATA,  OUT_DATA4;
   logic [1:0]    OCCUPANCY, OCCUPANCY4;
   logic [15:0]   STALL_CNT;
   logic [3:0]    STALL_CNT4;

   skid_pipeline_register #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CTRL(OUT_CTRL), .OUT_DATA(OUT_DATA),
      .OCCUPANCY(OCCUPANCY), .STALL_CNT(STALL_CNT)
   );

   skid_pipeline_register #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut_sat (
      .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY4), .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID4), .OUT_READY(OUT_READY), .OUT_CTRL(OUT_CTRL4), .OUT_DATA(OUT_DATA4),
      .OCCUPANCY(OCCUPANCY4), .STALL_CNT(STALL_CNT4)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];
   bit   m_rdy_ok = 1'b0;
   int   m_cnt    = 0;
   int   m_cnt4   = 0;
   bit   m_inf;
   bit   m_outf;

   int checks   = 0;
   int failures = 0;

   function automatic bit m_in_ready();
      return m_rdy_ok && (q.size() < 2);
   endfunction

   // Model: FIFO of at most two entries, updated on every clock edge.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q.delete();
         m_rdy_ok = 1'b0;
         m_cnt    = 0;
         m_cnt4   = 0;
      end else begin
         m_inf  = IN_VALID && m_in_ready();
         m_outf = (q.size() > 0) && OUT_READY;
         if (q.size() > 0 && !OUT_READY) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15)   m_cnt4++;
         end
         if (FLUSH) begin
            q.delete();
         end else begin
            if (m_outf) void'(q.pop_front());
            if (m_inf)  q.push_back('{c: IN_CTRL, d: IN_DATA});
         end
         m_rdy_ok = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge CLK) begin
      chk("in_ready",   IN_READY,   m_in_ready());
      chk("out_valid",  OUT_VALID,  q.size() > 0);
      chk("occupancy",  OCCUPANCY,  q.size());
      chk("out_ctrl",   OUT_CTRL,   (q.size() > 0) ? q[0].c : '0);
      if (q.size() > 0) chk("out_data", OUT_DATA, q[0].d);
      chk("stall_cnt",  STALL_CNT,  m_cnt);
      chk("in_ready4",  IN_READY4,  m_in_ready());
      chk("out_valid4", OUT_VALID4, q.size() > 0);
      chk("occupancy4", OCCUPANCY4, q.size());
      chk("out_ctrl4",  OUT_CTRL4,  (q.size() > 0) ? q[0].c : '0);
      if (q.size() > 0) chk("out_data4", OUT_DATA4, q[0].d);
      chk("stall_cnt4", STALL_CNT4, m_cnt4);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #1;
      RST_N = 1'b1;
      tick();
   endtask

   logic [127:0] rnd;

   initial begin
      RST_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
      IN_CTRL = '0; IN_DATA = '0;
      repeat (2) @(posedge CLK);
      #2;
      RST_N = 1'b1;
      chk("reset_in_ready_low", IN_READY, 1'b0);
      chk("reset_out_ctrl", OUT_CTRL, 8'h00);
      tick();
      chk("reset_in_ready_high", IN_READY, 1'b1);
      chk("reset_occupancy", OCCUPANCY, 2'd0);
      chk("reset_stall_cnt", STALL_CNT, 16'd0);

      // Streaming: one-cycle latency, one entry per cycle.
      OUT_READY = 1'b1;
      IN_VALID  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         IN_DATA = DW'(i);
         IN_CTRL = CW'(i);
         tick();
         chk("stream_data", OUT_DATA, i);
         chk("stream_occ", OCCUPANCY, 2'd1);
      end
      IN_VALID = 1'b0;
      tick();
      chk("stream_drain", OUT_VALID, 1'b0);

      // Back-pressure with 0xA then 0xB.
      do_reset();
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1; IN_CTRL = 8'h0A; IN_DATA = DW'(8'h0A);
      tick();
      chk("bp_occ1", OCCUPANCY, 2'd1);
      IN_CTRL = 8'h0B; IN_DATA = DW'(8'h0B);
      tick();
      chk("bp_occ2", OCCUPANCY, 2'd2);
      chk("bp_in_ready", IN_READY, 1'b0);
      chk("bp_stall1", STALL_CNT, 16'd1);
      IN_VALID = 1'b0;
      tick();
      chk("bp_stall2", STALL_CNT, 16'd2);
      OUT_READY = 1'b1;
      #1;
      chk("bp_first", OUT_DATA, 8'h0A);
      tick();
      chk("bp_second", OUT_DATA, 8'h0B);
      chk("bp_second_ctrl", OUT_CTRL, 8'h0B);
      chk("bp_stall_final", STALL_CNT, 16'd2);
      tick();
      chk("bp_empty", OUT_VALID, 1'b0);

      // Flush while FULL with an offered entry.
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1; IN_CTRL = 8'h11; IN_DATA = DW'(1);
      tick();
      IN_CTRL = 8'h22; IN_DATA = DW'(2);
      tick();
      IN_CTRL = 8'hFF; IN_DATA = DW'(8'h3F); FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0; IN_VALID = 1'b0;
      chk("flush_valid", OUT_VALID, 1'b0);
      chk("flush_ctrl", OUT_CTRL, 8'h00);
      chk("flush_occ", OCCUPANCY, 2'd0);
      chk("flush_in_ready", IN_READY, 1'b1);
      OUT_READY = 1'b1;
      repeat (3) begin
         tick();
         chk("flush_no_ghost", OUT_VALID, 1'b0);
      end

      // Flush in ONE with a same-cycle accepted input.
      OUT_READY = 1'b0;
      IN_VALID = 1'b1; IN_CTRL = 8'h33; IN_DATA = DW'(3);
      tick();
      IN_CTRL = 8'hFF; FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0; IN_VALID = 1'b0;
      chk("flush_one_occ", OCCUPANCY, 2'd0);

      // Asynchronous reset pulse mid-cycle in ONE.
      IN_VALID = 1'b1; IN_CTRL = 8'h81; IN_DATA = DW'(8'h81);
      tick();
      IN_VALID = 1'b0;
      chk("arst_pre_ctrl", OUT_CTRL, 8'h81);
      #1 RST_N = 1'b0;
      #1;
      chk("arst_ctrl", OUT_CTRL, 8'h00);
      chk("arst_in_ready", IN_READY, 1'b0);
      chk("arst_valid", OUT_VALID, 1'b0);
      RST_N = 1'b1;
      #2;
      chk("arst_release_ready", IN_READY, 1'b0);
      tick();
      chk("arst_ready_after_edge", IN_READY, 1'b1);

      // Saturation of the 4-bit counter.
      do_reset();
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1; IN_CTRL = 8'h44; IN_DATA = DW'(4);
      tick();
      IN_VALID = 1'b0;
      repeat (20) tick();
      chk("sat_cnt4", STALL_CNT4, 4'd15);
      chk("sat_cnt16", STALL_CNT, 16'd20);
      OUT_READY = 1'b1;
      tick();

      // Random traffic with flushes; IN_READY must not follow OUT_READY within a cycle.
      for (int n = 0; n < 10000; n++) begin
         IN_VALID  = ($urandom_range(0, 3) != 0);
         OUT_READY = ($urandom_range(0, 2) != 0);
         FLUSH     = ($urandom_range(0, 63) == 0);
         IN_CTRL   = CW'($urandom);
         rnd       = {$urandom, $urandom, $urandom, $urandom};
         IN_DATA   = rnd[DW-1:0];
         OUT_READY = ~OUT_READY;
         #1;
         chk("ready_comb", IN_READY, m_in_ready());
         OUT_READY = ~OUT_READY;
         tick();
      end

      FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
